if_prefetch_queue: RTL

- Instruction prefetch stage that sits upstream of the pipeline's instruction-fetch segment.
- Runs ahead of the consumer and issues word fetches to instruction memory over a req/ack handshake that tolerates variable memory latency.
- Buffers fetched words together with their PC in a small FIFO and presents them to the fetch segment with a valid/ready handshake.
- Flushes the FIFO and restarts fetching on a taken-branch redirect from EX.

---
 rtl/if_prefetch_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetches words ahead of the fetch segment over a
// req/ack memory port, buffers {ir, pc} in a circular FIFO, flushes on redirect.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ir,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_npc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_run_en;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     w_fetch_pc_nxt;
  logic [31:0]     r_pending_pc;
  logic [31:0]     w_pending_pc_nxt;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_ir [DEPTH];
  logic [31:0]     r_pc [DEPTH];
  logic            w_enq;
  logic            w_deq;
  logic            w_flush;

  // Head of the FIFO is presented combinationally.
  assign out_ir  = r_ir[r_rd_ptr];
  assign out_pc  = r_pc[r_rd_ptr];
  assign out_npc = out_pc + 32'd4;
  assign count   = r_count;

  // Next-state, memory request and FIFO control.
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_pending_pc_nxt = r_pending_pc;
    w_enq            = 1'b0;
    w_flush          = 1'b0;
    imem_req         = 1'b0;
    imem_addr        = r_fetch_pc;
    out_valid        = (r_count != '0) & ~redirect;
    w_deq            = out_valid & out_ready;

    case (r_state)
      ST_RUN: begin
        // Requests only go out with a free slot, so every acked word fits.
        imem_req = r_run_en & (r_count < CW'(DEPTH));
        if (redirect) begin
          w_flush = 1'b1;
          if (imem_req & ~imem_ack) begin
            // Keep the outstanding address stable; retire it in DISCARD.
            w_pending_pc_nxt = redirect_pc;
            w_state_nxt      = ST_DISCARD;
          end else begin
            w_fetch_pc_nxt = redirect_pc;
          end
        end else if (imem_req & imem_ack) begin
          w_enq          = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      ST_DISCARD: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_flush          = 1'b1;
          w_pending_pc_nxt = redirect_pc;
        end
        if (imem_ack) begin
          w_fetch_pc_nxt = redirect ? redirect_pc : r_pending_pc;
          w_state_nxt    = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State, PC and FIFO registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_run_en     <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= RESET_PC;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ir[PW'(i)] <= '0;
        r_pc[PW'(i)] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_run_en     <= 1'b1;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_pending_pc <= w_pending_pc_nxt;
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) begin
          r_ir[r_wr_ptr] <= imem_data;
          r_pc[r_wr_ptr] <= r_fetch_pc;
          r_wr_ptr       <= r_wr_ptr + PW'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      end
    end
  end

endmodule
